// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the fetch-stage program counter
package pc_pkg;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JAL    = 2'd2,
        JALR   = 2'd3
    } pc_src_e;

    localparam int unsigned PC_INC = 4;

    // Low target bits that must be zero once JALR has cleared bit 0.
    localparam logic [1:0] ALIGN_MASK = 2'b10;

endpackage

// File: rtl/return_addr_stack.sv
// rtl/return_addr_stack.sv - circular return-address stack with saturating count
module return_addr_stack #(
    parameter int ADDR_WIDTH = 32,
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_data,
    output logic [ADDR_WIDTH-1:0] top,
    output logic                  empty,
    output logic                  full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_idx;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign top   = mem_q[ptr_q];

    // Pushing while full lands on ptr+1, which is the oldest slot, so the
    // overwrite is implicit in the circular pointer.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && pop && !empty) begin
            wr_en = 1'b1;
        end else if (push) begin
            ptr_d  = ptr_q + 1'b1;
            wr_idx = ptr_q + 1'b1;
            wr_en  = 1'b1;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with branch/jump modes, redirect, stall and RAS
module pc_unit
    import pc_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic [1:0]            pc_src,
    input  logic                  br_taken,
    input  logic [ADDR_WIDTH-1:0] imm,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic                  link_push,
    input  logic                  ret_pop,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4,
    output logic                  misalign,
    output logic                  ras_empty,
    output logic                  ras_full
);

    pc_src_e               mode;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  misalign_q, misalign_d;
    logic [ADDR_WIDTH-1:0] target;
    logic [ADDR_WIDTH-1:0] jalr_sum;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  check_align;
    logic                  is_jump;
    logic                  bad_target;
    logic                  ras_push;
    logic                  ras_pop;

    assign mode     = pc_src_e'(pc_src);
    assign pc_plus4 = pc_q + ADDR_WIDTH'(PC_INC);
    assign jalr_sum = rs1 + imm;
    assign pc       = pc_q;
    assign misalign = misalign_q;

    always_comb begin
        target      = pc_plus4;
        check_align = 1'b0;
        is_jump     = 1'b0;
        unique case (mode)
            SEQ: begin
                target = pc_plus4;
            end
            BRANCH: begin
                target      = br_taken ? (pc_q + imm) : pc_plus4;
                check_align = br_taken;
            end
            JAL: begin
                target      = pc_q + imm;
                check_align = 1'b1;
                is_jump     = 1'b1;
            end
            JALR: begin
                // An empty RAS cannot predict, so a return falls back to rs1+imm.
                target      = (ret_pop && !ras_empty) ? ras_top
                                                      : {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
                check_align = 1'b1;
                is_jump     = 1'b1;
            end
        endcase
    end

    assign bad_target = check_align && (|(target[1:0] & ALIGN_MASK));

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        if (flush) begin
            pc_d       = flush_pc;
            misalign_d = 1'b0;
        end else if (!stall) begin
            misalign_d = bad_target;
            if (!bad_target) begin
                pc_d     = target;
                ras_push = is_jump && link_push;
                ras_pop  = (mode == JALR) && ret_pop;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit with a queue-based reference model
module tb_pc_unit;

    localparam int          AW    = 32;
    localparam logic [31:0] RPC   = 32'h100;
    localparam int          DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, br_taken, link_push, ret_pop;
    logic [AW-1:0] flush_pc, imm, rs1;
    logic [1:0]    pc_src;
    logic [AW-1:0] pc, pc_plus4;
    logic          misalign, ras_empty, ras_full;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras [$];

    pc_unit #(.ADDR_WIDTH(AW), .RESET_PC(RPC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
        .pc_src(pc_src), .br_taken(br_taken), .imm(imm), .rs1(rs1),
        .link_push(link_push), .ret_pop(ret_pop), .pc(pc), .pc_plus4(pc_plus4),
        .misalign(misalign), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; flush = 0; flush_pc = 0; pc_src = 2'd0; br_taken = 0;
        imm = 0; rs1 = 0; link_push = 0; ret_pop = 0;
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_mis = 0;
        m_ras.delete();
    endtask

    // Predicts the next state from the current inputs, straight from the mode rules.
    task automatic model_apply();
        logic [31:0] t, old;
        bit chk;
        old = m_pc;
        chk = 0;
        if (flush) begin
            m_pc = flush_pc;
            m_mis = 0;
        end else if (!stall) begin
            case (pc_src)
                2'd0: t = old + 4;
                2'd1: begin t = br_taken ? old + imm : old + 4; chk = br_taken; end
                2'd2: begin t = old + imm; chk = 1; end
                default: begin
                    if (ret_pop && m_ras.size() > 0) t = m_ras[m_ras.size()-1];
                    else t = (rs1 + imm) & 32'hFFFF_FFFE;
                    chk = 1;
                end
            endcase
            if (chk && t[1]) begin
                m_mis = 1;
            end else begin
                m_mis = 0;
                m_pc = t;
                if (pc_src == 2'd3 && link_push && ret_pop && m_ras.size() > 0) begin
                    m_ras[m_ras.size()-1] = old + 4;
                end else if (pc_src >= 2'd2 && link_push) begin
                    m_ras.push_back(old + 4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (pc_src == 2'd3 && ret_pop && m_ras.size() > 0) begin
                    void'(m_ras.pop_back());
                end
            end
        end
    endtask

    task automatic cyc();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] a);
        idle();
        flush = 1;
        flush_pc = a;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp_seq [3];
        exp_seq = '{32'h104, 32'h108, 32'h10C};
        rst = 1;
        idle();
        model_reset();
        #12;
        n_cmp++; if (pc !== 32'h100) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, 32'h100); end
        n_cmp++; if (pc_plus4 !== 32'h104) begin n_err++; $display("FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'h104); end
        n_cmp++; if ({misalign, ras_empty, ras_full} !== 3'b010) begin n_err++; $display("FAIL reset_flags: got %b want 010", {misalign, ras_empty, ras_full}); end
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (pc !== exp_seq[i]) begin n_err++; $display("FAIL seq_%0d: got %h want %h", i, pc, exp_seq[i]); end
        end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL seq_ras_empty: got %b want 1", ras_empty); end
    endtask

    task automatic test_branch();
        go_to(32'h20);
        pc_src = 2'd1; br_taken = 1; imm = 32'hFFFF_FFF0;
        cyc();
        n_cmp++; if (pc !== 32'h10) begin n_err++; $display("FAIL br_taken: got %h want %h", pc, 32'h10); end
        go_to(32'h20);
        pc_src = 2'd1; br_taken = 0; imm = 32'hFFFF_FFF0;
        cyc();
        n_cmp++; if (pc !== 32'h24) begin n_err++; $display("FAIL br_not_taken: got %h want %h", pc, 32'h24); end
        go_to(32'hFFFF_FFFC);
        n_cmp++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_plus4: got %h want 0", pc_plus4); end
        cyc();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_seq: got %h want 0", pc); end
    endtask

    task automatic test_misalign();
        go_to(32'h40);
        pc_src = 2'd3; rs1 = 32'h81; imm = 32'h1; link_push = 1;
        cyc();
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL mis_pc_hold: got %h want %h", pc, 32'h40); end
        n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1", misalign); end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL mis_ras_hold: got %b want 1", ras_empty); end
        idle();
        cyc();
        n_cmp++; if ({pc, misalign} !== {32'h44, 1'b0}) begin n_err++; $display("FAIL mis_clear: got %h/%b want 44/0", pc, misalign); end
        pc_src = 2'd3; rs1 = 32'h81; imm = 32'h1;
        cyc();
        idle(); stall = 1;
        cyc();
        n_cmp++; if ({pc, misalign} !== {32'h44, 1'b1}) begin n_err++; $display("FAIL mis_stall_hold: got %h/%b want 44/1", pc, misalign); end
        idle();
        cyc();
        n_cmp++; if ({pc, misalign} !== {32'h48, 1'b0}) begin n_err++; $display("FAIL mis_after_stall: got %h/%b want 48/0", pc, misalign); end
    endtask

    task automatic test_call_return();
        go_to(32'h200);
        pc_src = 2'd2; imm = 32'h100; link_push = 1;
        cyc();
        n_cmp++; if ({pc, ras_empty} !== {32'h300, 1'b0}) begin n_err++; $display("FAIL call: got %h/%b want 300/0", pc, ras_empty); end
        idle();
        pc_src = 2'd3; ret_pop = 1; rs1 = 0; imm = 0;
        cyc();
        n_cmp++; if ({pc, ras_empty} !== {32'h204, 1'b1}) begin n_err++; $display("FAIL return: got %h/%b want 204/1", pc, ras_empty); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_ret [4];
        exp_ret = '{32'h44, 32'h34, 32'h24, 32'h14};
        go_to(32'h0);
        for (int i = 0; i < 5; i++) begin
            pc_src = 2'd2; imm = 32'h10; link_push = 1;
            cyc();
        end
        n_cmp++; if ({pc, ras_full} !== {32'h50, 1'b1}) begin n_err++; $display("FAIL ovf_full: got %h/%b want 50/1", pc, ras_full); end
        idle();
        for (int i = 0; i < 4; i++) begin
            pc_src = 2'd3; ret_pop = 1; rs1 = 32'h1000; imm = 32'h4;
            cyc();
            n_cmp++; if (pc !== exp_ret[i]) begin n_err++; $display("FAIL ovf_pop_%0d: got %h want %h", i, pc, exp_ret[i]); end
            if (i == 0) begin
                n_cmp++; if (ras_full !== 1'b0) begin n_err++; $display("FAIL ovf_not_full: got %b want 0", ras_full); end
            end
        end
        n_cmp++; if (ras_empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty: got %b want 1", ras_empty); end
        cyc();
        n_cmp++; if (pc !== 32'h1004) begin n_err++; $display("FAIL ovf_fallback: got %h want %h", pc, 32'h1004); end
        idle();
    endtask

    task automatic test_priority();
        idle();
        flush = 1; stall = 1; flush_pc = 32'h800; pc_src = 2'd2; imm = 32'h40; link_push = 1;
        cyc();
        n_cmp++; if ({pc, ras_empty} !== {32'h800, 1'b1}) begin n_err++; $display("FAIL prio_flush: got %h/%b want 800/1", pc, ras_empty); end
        idle();
        pc_src = 2'd2; imm = 32'h40; link_push = 1;
        cyc();
        stall = 1;
        cyc();
        n_cmp++; if ({pc, ras_empty} !== {32'h840, 1'b0}) begin n_err++; $display("FAIL prio_stall: got %h/%b want 840/0", pc, ras_empty); end
        #2;
        rst = 1;
        #1;
        n_cmp++; if ({pc, pc_plus4} !== {RPC, RPC + 32'h4}) begin n_err++; $display("FAIL async_rst_pc: got %h/%h want %h", pc, pc_plus4, RPC); end
        n_cmp++; if ({misalign, ras_empty, ras_full} !== 3'b010) begin n_err++; $display("FAIL async_rst_flags: got %b want 010", {misalign, ras_empty, ras_full}); end
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall     = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            flush_pc  = $urandom & 32'hFFFF_FFFC;
            pc_src    = 2'($urandom_range(0, 3));
            br_taken  = 1'($urandom_range(0, 1));
            imm       = ($urandom & 32'h0000_FFFC) | (($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0);
            rs1       = $urandom;
            link_push = 1'($urandom_range(0, 1));
            ret_pop   = 1'($urandom_range(0, 1));
            cyc();
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
            n_cmp++; if (pc_plus4 !== m_pc + 32'h4) begin n_err++; $display("FAIL rnd_plus4[%0d]: got %h want %h", i, pc_plus4, m_pc + 32'h4); end
            n_cmp++; if (misalign !== m_mis) begin n_err++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, misalign, m_mis); end
            n_cmp++; if (ras_empty !== (m_ras.size() == 0)) begin n_err++; $display("FAIL rnd_empty[%0d]: got %b want %b", i, ras_empty, m_ras.size() == 0); end
            n_cmp++; if (ras_full !== (m_ras.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full[%0d]: got %b want %b", i, ras_full, m_ras.size() == DEPTH); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_branch();
        test_misalign();
        test_call_return();
        test_ras_overflow();
        test_priority();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
